// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised RX pin, 2-of-3 mid-bit majority sampling, stop-bit check,
// and a holding register with a valid/ack handshake plus framing and overrun strobes.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 60
) (
  input  logic       clk60,
  input  logic       rst,
  input  logic       rx_pin,
  input  logic       rx_ack,
  output logic [7:0] rxdata,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned H = CLKS_PER_BIT / 2;
  localparam logic [11:0] CntLast = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] CntS0   = 12'(H - 1);
  localparam logic [11:0] CntS1   = 12'(H);
  localparam logic [11:0] CntDec  = 12'(H + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e      state;
  logic        s1, s2, s3;
  logic [11:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic [1:0]  samp;
  logic        maj, decide, wrap, fall;

  assign maj    = (samp[0] & samp[1]) | (samp[0] & s2) | (samp[1] & s2);
  assign decide = (cnt == CntDec);
  assign wrap   = (cnt == CntLast);
  assign fall   = s3 & ~s2;

  always_ff @(posedge clk60) begin
    if (rst) begin
      state     <= StIdle;
      s1        <= 1'b1;
      s2        <= 1'b1;
      s3        <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      samp      <= '0;
      rxdata    <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      s1        <= rx_pin;
      s2        <= s1;
      s3        <= s2;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_ack) rx_valid <= 1'b0;

      if (cnt == CntS0) samp[0] <= s2;
      if (cnt == CntS1) samp[1] <= s2;

      if (state == StIdle || state == StBreak) cnt <= '0;
      else if (wrap)                           cnt <= '0;
      else                                     cnt <= cnt + 12'd1;

      case (state)
        StIdle: begin
          if (fall) begin
            state   <= StStart;
            rx_busy <= 1'b1;
          end
        end
        StStart: begin
          if (decide && maj) begin
            state   <= StIdle;
            rx_busy <= 1'b0;
          end else if (wrap) begin
            state <= StData;
            idx   <= '0;
          end
        end
        StData: begin
          if (decide) sh <= {maj, sh[7:1]};
          if (wrap) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= StStop;
          end
        end
        StStop: begin
          if (decide) begin
            if (maj) begin
              state   <= StIdle;
              rx_busy <= 1'b0;
              // A same-cycle ack frees the register, so the new byte replaces the old one.
              if (!rx_valid || rx_ack) begin
                rxdata   <= sh;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= StBreak;
            end
          end
        end
        StBreak: begin
          // No edge detection while the line is held low: one frame_err per break.
          if (s2) begin
            state   <= StIdle;
            rx_busy <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: timing of acceptance, glitch rejection, framing/break, overrun,
// back-to-back frames, coincident ack and mid-frame reset.
module tb_uart_rx;

  localparam int C = 60;
  localparam int H = C / 2;

  logic       clk60 = 1'b0;
  logic       rst = 1'b1;
  logic       rx_pin = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rxdata;
  logic       rx_valid, frame_err, overrun, rx_busy;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int ferr_base, ovr_base;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk60    (clk60),
    .rst      (rst),
    .rx_pin   (rx_pin),
    .rx_ack   (rx_ack),
    .rxdata   (rxdata),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  always #5 clk60 = ~clk60;

  always @(negedge clk60) begin
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk60);
      #1;
    end
  endtask

  // Drives one frame bit-by-bit; glitch_bit inverts one cycle sampled at cnt=H of that bit;
  // stop_after>0 abandons the frame after that many cycles.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int glitch_bit,
                            input int stop_after);
    logic [9:0] bits;
    int k;
    bits = {stop, data, 1'b0};
    k = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < C; j++) begin
        if (stop_after > 0 && k == stop_after) return;
        rx_pin = (i == glitch_bit && j == H + 1) ? ~bits[i] : bits[i];
        tick(1);
        k++;
      end
    end
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] v;

    rst = 1'b1;
    tick(3);
    check_eq("reset_rxdata", rxdata, 8'h00);
    check_eq("reset_valid", rx_valid, 1'b0);
    check_eq("reset_busy", rx_busy, 1'b0);
    check_eq("reset_ferr", frame_err, 1'b0);
    check_eq("reset_ovr", overrun, 1'b0);
    rst = 1'b0;
    tick(5);

    // 0xA5: acceptance exactly 575 cycles after the pin falls (E = fall + 3, E + 572).
    fork
      send_frame(8'hA5, 1'b1, -1, 0);
      begin
        tick(2);
        check_eq("a5_busy_pre", rx_busy, 1'b0);
        tick(2);
        check_eq("a5_busy_run", rx_busy, 1'b1);
        tick(570);
        check_eq("a5_valid_early", rx_valid, 1'b0);
        tick(1);
        check_eq("a5_valid", rx_valid, 1'b1);
        check_eq("a5_data", rxdata, 8'hA5);
        check_eq("a5_busy_done", rx_busy, 1'b0);
      end
    join
    check_eq("a5_no_ferr", ferr_cnt, 0);
    check_eq("a5_no_ovr", ovr_cnt, 0);
    ack_pulse();
    check_eq("a5_ack_clears", rx_valid, 1'b0);
    ack_pulse();
    check_eq("idle_ack_ignored", rx_valid, 1'b0);

    // 20-cycle low glitch: false start rejected at the start-bit decision.
    rx_pin = 1'b0;
    tick(4);
    check_eq("glitch_busy", rx_busy, 1'b1);
    tick(16);
    rx_pin = 1'b1;
    tick(16);
    check_eq("glitch_idle", rx_busy, 1'b0);
    tick(50);
    check_eq("glitch_no_valid", rx_valid, 1'b0);
    check_eq("glitch_no_ferr", ferr_cnt, 0);

    // Single-cycle spike inside data bit 0 of 0x55 is out-voted.
    send_frame(8'h55, 1'b1, 1, 0);
    check_eq("spike_valid", rx_valid, 1'b1);
    check_eq("spike_data", rxdata, 8'h55);
    ack_pulse();

    // Stop bit low followed by a long break: exactly one frame_err.
    ferr_base = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1, 0);
    rx_pin = 1'b0;
    tick(2000);
    check_eq("break_one_ferr", ferr_cnt - ferr_base, 1);
    check_eq("break_no_valid", rx_valid, 1'b0);
    check_eq("break_busy", rx_busy, 1'b1);
    rx_pin = 1'b1;
    tick(10);
    check_eq("break_exit", rx_busy, 1'b0);
    send_frame(8'h81, 1'b1, -1, 0);
    check_eq("after_break_data", rxdata, 8'h81);
    check_eq("after_break_valid", rx_valid, 1'b1);
    check_eq("after_break_ferr", ferr_cnt - ferr_base, 1);
    ack_pulse();

    // Back-to-back 0x00, 0xFF; ack on the first acceptance cycle.
    ovr_base = ovr_cnt;
    fork
      begin
        send_frame(8'h00, 1'b1, -1, 0);
        send_frame(8'hFF, 1'b1, -1, 0);
      end
      begin
        tick(575);
        check_eq("b2b_first_valid", rx_valid, 1'b1);
        check_eq("b2b_first_data", rxdata, 8'h00);
        ack_pulse();
        check_eq("b2b_first_acked", rx_valid, 1'b0);
      end
    join
    check_eq("b2b_second_valid", rx_valid, 1'b1);
    check_eq("b2b_second_data", rxdata, 8'hFF);
    check_eq("b2b_no_ovr", ovr_cnt - ovr_base, 0);
    ack_pulse();

    // 0x12 then 0x34 without ack: second byte lost with one overrun.
    send_frame(8'h12, 1'b1, -1, 0);
    send_frame(8'h34, 1'b1, -1, 0);
    check_eq("ovr_pulse", ovr_cnt - ovr_base, 1);
    check_eq("ovr_keep_data", rxdata, 8'h12);
    check_eq("ovr_keep_valid", rx_valid, 1'b1);

    // Ack in the stop-decision cycle while 0x12 is pending: 0x5A loads, no overrun.
    fork
      send_frame(8'h5A, 1'b1, -1, 0);
      begin
        tick(574);
        ack_pulse();
        check_eq("coinc_valid", rx_valid, 1'b1);
        check_eq("coinc_data", rxdata, 8'h5A);
      end
    join
    check_eq("coinc_no_ovr", ovr_cnt - ovr_base, 1);
    ack_pulse();

    // Reset during data bit 4 of 0x77.
    send_frame(8'h77, 1'b1, -1, 5 * C + H);
    check_eq("prerst_busy", rx_busy, 1'b1);
    rst = 1'b1;
    tick(1);
    check_eq("rst_rxdata", rxdata, 8'h00);
    check_eq("rst_valid", rx_valid, 1'b0);
    check_eq("rst_busy", rx_busy, 1'b0);
    check_eq("rst_ferr", frame_err, 1'b0);
    check_eq("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    rx_pin = 1'b1;
    tick(20);
    send_frame(8'hC3, 1'b1, -1, 0);
    check_eq("post_rst_data", rxdata, 8'hC3);
    check_eq("post_rst_valid", rx_valid, 1'b1);
    ack_pulse();

    // Sweep of characters, acked after each.
    for (int n = 0; n < 16; n++) begin
      v = 8'(16 * n + 1);
      send_frame(v, 1'b1, -1, 0);
      check_eq("sweep_data", rxdata, v);
      ack_pulse();
    end
    check_eq("final_ferr", ferr_cnt - ferr_base, 1);
    check_eq("final_ovr", ovr_cnt - ovr_base, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous UART receiver (8N1, LSB first) that sits directly upstream of the design's consumer logic and is the receive-side counterpart of the `uart_tx` stage on the same 60 MHz domain. It synchronises the raw RX pin, detects and validates start bits, majority-samples each bit at mid-bit, and checks the stop bit. It presents each received byte in a holding register with a valid/ack handshake, and flags framing and overrun errors.

## Interface
- CLKS_PER_BIT, 60, clk60 cycles per bit (60 MHz / 1 MBaud); legal range 8..4095.
- clk60  in  1  system clock, 60 MHz; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rx_pin  in  1  raw asynchronous serial line; idle high.
- rxdata  out  8  last accepted byte; held until the next accepted byte.
- rx_valid  out  1  level; high while rxdata holds an unacknowledged byte.
- rx_ack  in  1  one-cycle consume strobe; clears rx_valid.
- frame_err  out  1  one-cycle strobe: stop bit sampled low.
- overrun  out  1  one-cycle strobe: byte completed while rx_valid was still high.
- rx_busy  out  1  high from start-edge detection until return to IDLE.

## Operation
- Input path: two-flop synchroniser (`s1`, `s2`), reset to 1, plus a one-cycle delayed copy `s3` for edge detection.
- Bit timer: `cnt` counts 0..CLKS_PER_BIT-1, then wraps and advances the bit. Define H = CLKS_PER_BIT/2, integer division.
- Sampling: three samples of `s2`, taken at cnt = H-1, H and H+1; the bit value is their 2-of-3 majority. It is decided at cnt = H+1.
- States:
  - IDLE: rx_busy=0. A falling edge (`s3`=1, `s2`=0) enters START with cnt=0.
  - START: at the decision point, majority 1 is a false start: return to IDLE with no strobe. Majority 0 continues; at the wrap, go to DATA with bit index 0.
  - DATA: shift the majority value into bit[index], LSB first. After index 7 wraps, go to STOP.
  - STOP: at the decision point, act on the stop bit:
    - 1: accept the byte and go to IDLE on the next cycle.
    - 0: pulse frame_err, discard the byte, go to BREAK_WAIT.
  - BREAK_WAIT: stay until `s2`=1, then IDLE. No edge detection here, so a break condition yields exactly one frame_err.
- Acceptance, in the cycle after the stop decision:
  - rx_valid=0: load rxdata and set rx_valid=1.
  - rx_valid=1: pulse overrun and keep the old rxdata and rx_valid=1; the new byte is lost.
- rx_ack clears rx_valid on the next edge. Acceptance and ack in the same cycle: ack clears the old byte, the new byte loads, rx_valid stays 1, no overrun.
- rx_ack while rx_valid=0: ignored.
- Reset, including mid-frame: state IDLE, cnt 0, synchroniser flops 1, rxdata 0x00, rx_valid 0, frame_err 0, overrun 0, rx_busy 0. A partially received byte is discarded. The next start edge after reset must be a genuine 1→0 transition.

## Timing
- Pin-to-`s2` latency: 2 cycles. Edge detected (cycle E) 3 cycles after the pin falls.
- Stop decision at E + 9·CLKS_PER_BIT + H + 1. Acceptance / frame_err / overrun at that cycle + 1: E+572 for the defaults.
- rx_busy: 1 from E+1 to the decision cycle; 0 from the acceptance cycle.
  - The receiver re-arms about H cycles before the nominal end of the stop bit, which tolerates up to ±4% baud mismatch.
  - Back-to-back frames with no idle gap are received.
- Strobes are exactly 1 cycle wide.

## Test plan
- Byte 0xA5, defaults, ideal 1 MBaud → rx_valid rises at E+572 with rxdata=0xA5; no error strobes; rx_ack clears rx_valid 1 cycle later.
- 20-cycle low glitch on an idle line → rx_busy high for about 32 cycles, then IDLE; no rx_valid and no frame_err. A single-cycle low spike mid-bit during 0x55 → 0x55 received (majority vote).
- 0x3C with stop bit low, line held low 2000 cycles → exactly one frame_err pulse, rx_valid stays 0. After the line returns high, 0x81 is received correctly.
- 0x00 then 0xFF back-to-back, no gap, with rx_ack pulsed on the acceptance cycle of the first → both bytes delivered in order; no overrun.
- 0x12 then 0x34 with no rx_ack → one overrun pulse; rxdata stays 0x12 and rx_valid stays 1.
- rst asserted mid-data bit 4 of 0x77 → all outputs at reset values next cycle; subsequent 0xC3 received correctly. Loopback from uart_tx through the incrementing-character sequence 0x01..0xFF shows no mismatches.
